// File: rtl/conv_pkg.sv
// Shared types, widths and int8 saturation helpers for the conv post-processing stage.
package conv_pkg;

    localparam int NUM_LANES = 8;
    localparam int ACC_W     = 32;
    localparam int SCALE_W   = 16;
    localparam int PIX_W     = 8;
    localparam int SHIFT_W   = 5;
    localparam int LEAKY_MUL = 13;
    localparam int LEAKY_SHR = 7;
    localparam int WORD_W    = NUM_LANES * PIX_W;

    // acc * {0,scale} is 32 x 17 signed; the leaky multiply by 13 needs 5 more bits
    localparam int PROD_W  = ACC_W + SCALE_W + 1;
    localparam int LEAKY_W = PROD_W + 5;

    localparam logic signed [PROD_W-1:0]  PROD_ONE = PROD_W'(1);
    localparam logic signed [LEAKY_W-1:0] PIX_MAX  = LEAKY_W'(127);
    localparam logic signed [LEAKY_W-1:0] PIX_MIN  = LEAKY_W'(-128);

    typedef logic [NUM_LANES-1:0][ACC_W-1:0]   acc_vec_t;
    typedef logic [NUM_LANES-1:0][SCALE_W-1:0] scale_vec_t;
    typedef logic [WORD_W-1:0]                 pix_word_t;

    function automatic logic is_clipped(input logic signed [LEAKY_W-1:0] v);
        return (v > PIX_MAX) || (v < PIX_MIN);
    endfunction

    function automatic logic [PIX_W-1:0] sat_int8(input logic signed [LEAKY_W-1:0] v);
        logic [PIX_W-1:0] res;
        if (v > PIX_MAX) begin
            res = PIX_MAX[PIX_W-1:0];
        end else if (v < PIX_MIN) begin
            res = PIX_MIN[PIX_W-1:0];
        end else begin
            res = v[PIX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_postproc_if.sv
// Accumulator-in / pixel-out stream bundle; slave is the post-proc stage, master the environment.
interface conv_postproc_if;
    import conv_pkg::*;

    logic      in_valid;
    acc_vec_t  in_acc;
    pix_word_t out_data;
    logic      out_valid;
    logic      out_ready;

    modport master (
        output in_valid, in_acc, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_valid, in_acc, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/conv_postproc_sync_fifo.sv
// Synchronous FIFO with registered count/flags; a read frees the slot for a same-cycle write when full.
module sync_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     not_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wr_accept,
    output logic                     wr_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(AF_MARGIN);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]    count_r, count_nxt_s;
    logic             not_empty_r, af_r, rd_fire_s, wr_ok_s;

    // Handshake resolution and next occupancy
    always_comb begin
        rd_fire_s   = rd_en && not_empty_r;
        wr_ok_s     = wr_en && ((count_r != DEPTH_C) || rd_fire_s);
        count_nxt_s = count_r + CW'(wr_ok_s) - CW'(rd_fire_s);
    end

    // Storage, pointers and flags registered from the next-state count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            not_empty_r <= 1'b0;
            af_r        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r     <= count_nxt_s;
            not_empty_r <= (count_nxt_s != '0);
            af_r        <= ((DEPTH_C - count_nxt_s) <= MARGIN_C);
        end
    end

    assign rd_data     = mem_r[rd_ptr_r];
    assign not_empty   = not_empty_r;
    assign almost_full = af_r;
    assign count       = count_r;
    assign wr_accept   = wr_ok_s;
    assign wr_drop     = wr_en && !wr_ok_s;

endmodule

// File: rtl/conv_postproc.sv
// Conv post-processing: per-lane requantize, optional leaky ReLU, int8 saturate, pack, output FIFO.
// Defining CONV_POSTPROC_SAT_CNT_EN adds the sat_clr/sat_count lane-clip counter.
module conv_postproc
    import conv_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    conv_postproc_if.slave              bus,
    input  scale_vec_t                  cfg_scale,
    input  logic [SHIFT_W-1:0]          cfg_shift,
    input  logic                        cfg_leaky_en,
    output logic                        almost_full,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] occupancy
`ifdef CONV_POSTPROC_SAT_CNT_EN
    ,
    input  logic                        sat_clr,
    output logic [31:0]                 sat_count
`endif
);
    logic                      v1_r, v2_r, v3_r;
    logic signed [PROD_W-1:0]  prod1_r [NUM_LANES];
    logic [SHIFT_W-1:0]        shift1_r;
    logic                      leaky1_r, leaky2_r;
    logic signed [PROD_W-1:0]  rnd_s [NUM_LANES];
    logic signed [PROD_W-1:0]  r2_r  [NUM_LANES];
    logic signed [LEAKY_W-1:0] l_s   [NUM_LANES];
    pix_word_t                 word_s, word3_r;
    logic [3:0]                nsat_s, nsat3_r;
    logic                      wr_accept_s, wr_drop_s, overflow_r;

    // S1: per-lane product; shift and leaky mode travel with the beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r     <= 1'b0;
            shift1_r <= '0;
            leaky1_r <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) prod1_r[i] <= '0;
        end else begin
            v1_r <= bus.in_valid;
            if (bus.in_valid) begin
                shift1_r <= cfg_shift;
                leaky1_r <= cfg_leaky_en;
                for (int i = 0; i < NUM_LANES; i++) begin
                    prod1_r[i] <= PROD_W'($signed(bus.in_acc[i])) *
                                  PROD_W'($signed({1'b0, cfg_scale[i]}));
                end
            end
        end
    end

    // Round half up, then arithmetic shift (floor)
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (shift1_r != '0) begin
                rnd_s[i] = (prod1_r[i] + (PROD_ONE <<< (shift1_r - SHIFT_W'(1)))) >>> shift1_r;
            end else begin
                rnd_s[i] = prod1_r[i];
            end
        end
    end

    // S2 register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_r     <= 1'b0;
            leaky2_r <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) r2_r[i] <= '0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                leaky2_r <= leaky1_r;
                for (int i = 0; i < NUM_LANES; i++) r2_r[i] <= rnd_s[i];
            end
        end
    end

    // Leaky slope 13/128 on negatives, saturate to int8, pack and count clipped lanes
    always_comb begin
        word_s = '0;
        nsat_s = 4'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (leaky2_r && r2_r[i][PROD_W-1]) begin
                l_s[i] = (LEAKY_W'(r2_r[i]) * LEAKY_W'(LEAKY_MUL)) >>> LEAKY_SHR;
            end else begin
                l_s[i] = LEAKY_W'(r2_r[i]);
            end
            word_s[i*PIX_W +: PIX_W] = sat_int8(l_s[i]);
            nsat_s = nsat_s + {3'b000, is_clipped(l_s[i])};
        end
    end

    // S3 register feeding the FIFO write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v3_r    <= 1'b0;
            word3_r <= '0;
            nsat3_r <= 4'd0;
        end else begin
            v3_r <= v2_r;
            if (v2_r) begin
                word3_r <= word_s;
                nsat3_r <= nsat_s;
            end
        end
    end

    sync_fifo #(
        .WIDTH     (WORD_W),
        .DEPTH     (FIFO_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (v3_r),
        .wr_data     (word3_r),
        .rd_en       (bus.out_ready),
        .rd_data     (bus.out_data),
        .not_empty   (bus.out_valid),
        .almost_full (almost_full),
        .count       (occupancy),
        .wr_accept   (wr_accept_s),
        .wr_drop     (wr_drop_s)
    );

    // Sticky drop flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (wr_drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow = overflow_r;

`ifdef CONV_POSTPROC_SAT_CNT_EN
    logic [31:0] sat_count_r;
    logic [32:0] sat_sum_s;

    // Counter sum with carry for saturation at all-ones
    always_comb begin
        sat_sum_s = {1'b0, sat_count_r} + 33'(nsat3_r);
    end

    // Lane-clip counter; clear wins over increment, dropped vectors are not counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count_r <= 32'd0;
        end else if (sat_clr) begin
            sat_count_r <= 32'd0;
        end else if (wr_accept_s) begin
            sat_count_r <= sat_sum_s[32] ? 32'hFFFF_FFFF : sat_sum_s[31:0];
        end
    end

    assign sat_count = sat_count_r;
`endif

endmodule

// File: tb/tb_conv_postproc.sv
// Self-checking bench for conv_postproc: directed plan items plus randomized traffic vs. an arithmetic model.
module tb_conv_postproc;
    import conv_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    scale_vec_t cfg_scale;
    logic [4:0] cfg_shift;
    logic       cfg_leaky_en;
    logic       almost_full;
    logic       overflow;
    logic [4:0] occupancy;
`ifdef CONV_POSTPROC_SAT_CNT_EN
    logic        sat_clr;
    logic [31:0] sat_count;
`endif

    int checks   = 0;
    int failures = 0;
    pix_word_t exp_q[$];

    conv_postproc_if bus();

    conv_postproc #(.FIFO_DEPTH(16), .AF_MARGIN(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cfg_scale    (cfg_scale),
        .cfg_shift    (cfg_shift),
        .cfg_leaky_en (cfg_leaky_en),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .occupancy    (occupancy)
`ifdef CONV_POSTPROC_SAT_CNT_EN
        ,
        .sat_clr      (sat_clr),
        .sat_count    (sat_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] model_lane(input longint acc, input longint scale,
                                              input int sh, input bit lk);
        longint p, r, l;
        p = acc * scale;
        if (sh > 0) r = floor_div(p + (longint'(1) << (sh - 1)), longint'(1) << sh);
        else        r = p;
        if (lk && r < 0) l = floor_div(r * 13, 128);
        else             l = r;
        if (l > 127)       l = 127;
        else if (l < -128) l = -128;
        return l[7:0];
    endfunction

    function automatic pix_word_t model_word(input acc_vec_t a, input scale_vec_t s,
                                             input int sh, input bit lk);
        pix_word_t w;
        for (int i = 0; i < 8; i++)
            w[8*i +: 8] = model_lane(longint'($signed(a[i])), longint'(s[i]), sh, lk);
        return w;
    endfunction

    function automatic scale_vec_t all_scale(input int s);
        scale_vec_t v;
        for (int i = 0; i < 8; i++) v[i] = 16'(s);
        return v;
    endfunction

    function automatic acc_vec_t all_acc(input int a);
        acc_vec_t v;
        for (int i = 0; i < 8; i++) v[i] = 32'(a);
        return v;
    endfunction

    function automatic acc_vec_t rand_acc();
        acc_vec_t v;
        for (int i = 0; i < 8; i++)
            v[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'($urandom_range(0, 4000)) - 32'd2000);
        return v;
    endfunction

    function automatic scale_vec_t rand_scale();
        scale_vec_t v;
        for (int i = 0; i < 8; i++)
            v[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 300));
        return v;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_beat(input acc_vec_t a, input scale_vec_t s, input int sh,
                            input bit lk, input bit push);
        bus.in_valid = 1'b1;
        bus.in_acc   = a;
        cfg_scale    = s;
        cfg_shift    = 5'(sh);
        cfg_leaky_en = lk;
        if (push) exp_q.push_back(model_word(a, s, sh, lk));
    endtask

    task automatic beat(input acc_vec_t a, input scale_vec_t s, input int sh,
                        input bit lk, input bit push);
        set_beat(a, s, sh, lk, push);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int budget, output pix_word_t got[$]);
        got = {};
        bus.out_ready = 1'b1;
        for (int k = 0; k < budget && got.size() < n; k++) begin
            @(negedge clk);
            if (bus.out_valid) got.push_back(bus.out_data);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic reset_dut();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef CONV_POSTPROC_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q = {};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (bus.out_data !== 64'd0) begin failures++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
`ifdef CONV_POSTPROC_SAT_CNT_EN
        checks++; if (sat_count !== 32'd0) begin failures++; $display("FAIL reset_sat_count: got %0d want 0", sat_count); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rounding();
        acc_vec_t a;
        pix_word_t got[$];
        a = '0; a[0] = 32'd200;
        beat(a, all_scale(128), 8, 1'b0, 1'b0);
        drain(1, 20, got);
        checks++;
        if (got.size() != 1) begin failures++; $display("FAIL round_pos: got %0d words want 1", got.size()); end
        else if (got[0][7:0] !== 8'h64) begin failures++; $display("FAIL round_pos: got %h want 64", got[0][7:0]); end
        a = '0; a[1] = 32'hFFFF_FFFD;
        beat(a, all_scale(1), 1, 1'b0, 1'b0);
        drain(1, 20, got);
        checks++;
        if (got.size() != 1) begin failures++; $display("FAIL round_neg: got %0d words want 1", got.size()); end
        else if (got[0][15:8] !== 8'hFF) begin failures++; $display("FAIL round_neg: got %h want ff", got[0][15:8]); end
    endtask

    task automatic test_saturation_leaky();
        acc_vec_t a;
        pix_word_t got[$];
        a = '0; a[0] = 32'd1000; a[1] = 32'hFFFF_FC18;
        beat(a, all_scale(256), 8, 1'b1, 1'b0);
        drain(1, 20, got);
        checks++;
        if (got.size() != 1) begin failures++; $display("FAIL sat_leaky_on: got %0d words want 1", got.size()); end
        else if (got[0][15:0] !== 16'h9A7F) begin failures++; $display("FAIL sat_leaky_on: got %h want 9a7f", got[0][15:0]); end
        beat(a, all_scale(256), 8, 1'b0, 1'b0);
        drain(1, 20, got);
        checks++;
        if (got.size() != 1) begin failures++; $display("FAIL sat_leaky_off: got %0d words want 1", got.size()); end
        else if (got[0][15:0] !== 16'h807F) begin failures++; $display("FAIL sat_leaky_off: got %h want 807f", got[0][15:0]); end
    endtask

    task automatic test_latency_packing();
        acc_vec_t a;
        pix_word_t got[$];
        for (int i = 0; i < 8; i++) a[i] = 32'(i);
        set_beat(a, all_scale(1), 0, 1'b0, 1'b0);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (c >= 4)) begin failures++; $display("FAIL latency c=%0d: out_valid got %b want %b", c, bus.out_valid, (c >= 4)); end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
        drain(1, 5, got);
        checks++;
        if (got.size() != 1) begin failures++; $display("FAIL packing: got %0d words want 1", got.size()); end
        else if (got[0] !== 64'h0706050403020100) begin failures++; $display("FAIL packing: got %h want 0706050403020100", got[0]); end
    endtask

    task automatic test_back_pressure();
        pix_word_t got[$];
        int attempts, exp_occ;
        reset_dut();
        for (int c = 0; c < 25; c++) begin
            if (c < 17) set_beat(rand_acc(), rand_scale(), $urandom_range(0, 31), 1'($urandom_range(0, 1)), c < 16);
            else bus.in_valid = 1'b0;
            attempts = (c > 3) ? ((c - 3 > 17) ? 17 : c - 3) : 0;
            exp_occ  = (attempts > 16) ? 16 : attempts;
            @(negedge clk);
            checks++; if (occupancy !== 5'(exp_occ)) begin failures++; $display("FAIL bp_occupancy c=%0d: got %0d want %0d", c, occupancy, exp_occ); end
            checks++; if (almost_full !== ((16 - exp_occ) <= 4)) begin failures++; $display("FAIL bp_almost_full c=%0d: got %b want %b", c, almost_full, ((16 - exp_occ) <= 4)); end
            checks++; if (overflow !== (attempts > 16)) begin failures++; $display("FAIL bp_overflow c=%0d: got %b want %b", c, overflow, (attempts > 16)); end
            @(posedge clk); #1;
        end
        drain(16, 40, got);
        checks++;
        if (got.size() != 16) begin failures++; $display("FAIL bp_drain_count: got %0d want 16", got.size()); end
        for (int k = 0; k < got.size() && k < 16; k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin failures++; $display("FAIL bp_order k=%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: out_valid got %b want 0", bus.out_valid); end
        @(posedge clk); #1;
        exp_q = {};
    endtask

    task automatic test_full_simultaneous();
        pix_word_t got[$];
        pix_word_t head;
        reset_dut();
        for (int c = 0; c < 24; c++) begin
            if (c < 16 || c == 19) set_beat(rand_acc(), rand_scale(), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'b1);
            else bus.in_valid = 1'b0;
            bus.out_ready = (c == 22);
            @(negedge clk);
            if (c == 22) begin
                head = exp_q.pop_front();
                checks++; if (occupancy !== 5'd16) begin failures++; $display("FAIL fullrw_pre_occ: got %0d want 16", occupancy); end
                checks++; if (bus.out_data !== head) begin failures++; $display("FAIL fullrw_head: got %h want %h", bus.out_data, head); end
            end
            if (c == 23) begin
                checks++; if (occupancy !== 5'd16) begin failures++; $display("FAIL fullrw_occ: got %0d want 16", occupancy); end
                checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullrw_overflow: got %b want 0", overflow); end
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        drain(16, 40, got);
        checks++;
        if (got.size() != 16) begin failures++; $display("FAIL fullrw_drain_count: got %0d want 16", got.size()); end
        for (int k = 0; k < got.size() && k < 16; k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin failures++; $display("FAIL fullrw_order k=%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
        exp_q = {};
    endtask

    task automatic test_random();
        pix_word_t got[$];
        pix_word_t want;
        int n;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!almost_full && $urandom_range(0, 3) != 0)
                set_beat(rand_acc(), rand_scale(),
                         ($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : $urandom_range(0, 12),
                         1'($urandom_range(0, 1)), 1'b1);
            else
                bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_unexpected: got %h with empty scoreboard", bus.out_data);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.out_data !== want) begin failures++; $display("FAIL rand_data c=%0d: got %h want %h", c, bus.out_data, want); end
                end
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        n = exp_q.size();
        drain(n, 60, got);
        checks++;
        if (got.size() != n) begin failures++; $display("FAIL rand_drain_count: got %0d want %0d", got.size(), n); end
        for (int k = 0; k < got.size() && k < n; k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin failures++; $display("FAIL rand_drain k=%0d: got %h want %h", k, got[k], exp_q[k]); end
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow: got %b want 0", overflow); end
        exp_q = {};
    endtask

`ifdef CONV_POSTPROC_SAT_CNT_EN
    task automatic test_sat_count();
        pix_word_t got[$];
        acc_vec_t a;
        reset_dut();
        beat(all_acc(1000), all_scale(256), 8, 1'b0, 1'b0);
        drain(1, 20, got);
        checks++; if (sat_count !== 32'd8) begin failures++; $display("FAIL satcnt_8: got %0d want 8", sat_count); end
        a = '0; a[0] = 32'd1000;
        beat(a, all_scale(256), 8, 1'b0, 1'b0);
        drain(1, 20, got);
        checks++; if (sat_count !== 32'd9) begin failures++; $display("FAIL satcnt_9: got %0d want 9", sat_count); end
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        checks++; if (sat_count !== 32'd0) begin failures++; $display("FAIL satcnt_clr: got %0d want 0", sat_count); end
    endtask
`endif

    task automatic test_async_reset();
        bit seen;
        reset_dut();
        for (int c = 0; c < 11; c++) begin
            if (c < 10) set_beat(all_acc(1000), all_scale(256), 8, 1'b0, 1'b0);
            else bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        checks++; if (occupancy !== 5'd8) begin failures++; $display("FAIL areset_pre_occ: got %0d want 8", occupancy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL areset_occupancy: got %0d want 0", occupancy); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL areset_almost_full: got %b want 0", almost_full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL areset_overflow: got %b want 0", overflow); end
        checks++; if (bus.out_data !== 64'd0) begin failures++; $display("FAIL areset_out_data: got %h want 0", bus.out_data); end
`ifdef CONV_POSTPROC_SAT_CNT_EN
        checks++; if (sat_count !== 32'd0) begin failures++; $display("FAIL areset_sat_count: got %0d want 0", sat_count); end
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL areset_stale: out_valid seen after reset"); end
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL areset_post_occ: got %0d want 0", occupancy); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_acc    = '0;
        bus.out_ready = 1'b0;
        cfg_scale     = '0;
        cfg_shift     = 5'd0;
        cfg_leaky_en  = 1'b0;
`ifdef CONV_POSTPROC_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        test_reset();
        test_rounding();
        test_saturation_leaky();
        test_latency_packing();
        test_back_pressure();
        test_full_simultaneous();
        test_random();
`ifdef CONV_POSTPROC_SAT_CNT_EN
        test_sat_count();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
